// File: rtl/uart_rx_fifo_if.sv
// Byte-stream bundle between the Uart8 receiver, the rx FIFO and its consumer.
// slave is the FIFO's view; master is the receiver/consumer side.
interface uart_rx_fifo_if #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
);
    logic          rxDone;
    logic          rxErr;
    logic [7:0]    rxOut;
    logic          outValid;
    logic [7:0]    outByte;
    logic          outReady;
    logic [AW:0]   count;
    logic          full;
    logic          overflow;
    logic [7:0]    errCount;
    logic          clearFlags;

    modport slave (
        input  rxDone,
        input  rxErr,
        input  rxOut,
        input  outReady,
        input  clearFlags,
        output outValid,
        output outByte,
        output count,
        output full,
        output overflow,
        output errCount
    );

    modport master (
        output rxDone,
        output rxErr,
        output rxOut,
        output outReady,
        output clearFlags,
        input  outValid,
        input  outByte,
        input  count,
        input  full,
        input  overflow,
        input  errCount
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind the Uart8 receiver.
// Drops framing-error bytes (counted) and flags overflow when full.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    uart_rx_fifo_if.slave  bus
);
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          done_prev_q, done_prev_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic push, pop, good, bad, wr_en, is_full;

    assign is_full = (count_q == (AW+1)'(DEPTH));
    assign push    = bus.rxDone & ~done_prev_q;
    assign pop     = (count_q != '0) & bus.outReady;
    assign good    = push & ~bus.rxErr;
    assign bad     = push & bus.rxErr;
    // A pop frees the slot being written, so full+pop still accepts.
    assign wr_en   = good & (~is_full | pop);

    always_comb begin
        done_prev_d = bus.rxDone;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        err_cnt_d   = err_cnt_q;
        if (wr_en)
            wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)
            rd_ptr_d = rd_ptr_q + AW'(1);
        if (wr_en && !pop)
            count_d = count_q + (AW+1)'(1);
        else if (pop && !wr_en)
            count_d = count_q - (AW+1)'(1);
        if (good && is_full && !pop)
            overflow_d = 1'b1;
        if (bad && err_cnt_q != 8'hFF)
            err_cnt_d = err_cnt_q + 8'd1;
        if (bus.clearFlags) begin
            overflow_d = 1'b0;
            err_cnt_d  = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_prev_q <= 1'b1;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            done_prev_q <= done_prev_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[wr_ptr_q] <= bus.rxOut;
    end

    assign bus.outValid = (count_q != '0);
    assign bus.outByte  = mem_q[rd_ptr_q];
    assign bus.count    = count_q;
    assign bus.full     = is_full;
    assign bus.overflow = overflow_q;
    assign bus.errCount = err_cnt_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: vector table plus corner sequences.
module tb_uart_rx_fifo;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DEPTH(16)) bus ();

    uart_rx_fifo #(.DEPTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       done;
        logic       err;
        logic [7:0] din;
        logic       rdy;
        logic       clr;
        logic       e_valid;
        logic [7:0] e_byte;
        logic [4:0] e_count;
        logic       e_full;
        logic       e_ovf;
        logic [7:0] e_err;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b, input logic e);
        bus.rxOut  = b;
        bus.rxErr  = e;
        bus.rxDone = 1'b1;
        step();
        bus.rxDone = 1'b0;
        step();
    endtask

    task automatic pop_one();
        bus.outReady = 1'b1;
        step();
        bus.outReady = 1'b0;
    endtask

    function automatic vec_t mk(logic d, logic e, logic [7:0] x,
                                logic r, logic c, logic ev,
                                logic [7:0] eb, logic [4:0] ec,
                                logic ef, logic eo, logic [7:0] ee);
        vec_t v;
        v.done = d; v.err = e; v.din = x; v.rdy = r; v.clr = c;
        v.e_valid = ev; v.e_byte = eb; v.e_count = ec;
        v.e_full = ef; v.e_ovf = eo; v.e_err = ee;
        return v;
    endfunction

    initial begin
        logic [7:0] exp_rd;
        logic [7:0] exp_wr;

        tbl[0]  = mk(0,0,8'h00,0,0, 0,8'h00,0,0,0,0);
        tbl[1]  = mk(1,0,8'h56,0,0, 1,8'h56,1,0,0,0);
        tbl[2]  = mk(0,0,8'h00,0,0, 1,8'h56,1,0,0,0);
        tbl[3]  = mk(0,0,8'h00,1,0, 0,8'h00,0,0,0,0);
        tbl[4]  = mk(0,0,8'h00,0,0, 0,8'h00,0,0,0,0);
        tbl[5]  = mk(1,1,8'h56,0,0, 0,8'h00,0,0,0,1);
        tbl[6]  = mk(0,0,8'h00,0,0, 0,8'h00,0,0,0,1);
        tbl[7]  = mk(1,1,8'h56,0,0, 0,8'h00,0,0,0,2);
        tbl[8]  = mk(0,0,8'h00,0,0, 0,8'h00,0,0,0,2);
        tbl[9]  = mk(1,1,8'h56,0,0, 0,8'h00,0,0,0,3);
        tbl[10] = mk(0,0,8'h00,0,0, 0,8'h00,0,0,0,3);
        tbl[11] = mk(0,0,8'h00,0,1, 0,8'h00,0,0,0,0);
        tbl[12] = mk(0,0,8'h00,0,0, 0,8'h00,0,0,0,0);
        tbl[13] = mk(1,1,8'h56,0,1, 0,8'h00,0,0,0,0);
        tbl[14] = mk(0,0,8'h00,0,0, 0,8'h00,0,0,0,0);
        tbl[15] = mk(0,0,8'h00,1,0, 0,8'h00,0,0,0,0);

        bus.rxDone = 0; bus.rxErr = 0; bus.rxOut = 0;
        bus.outReady = 0; bus.clearFlags = 0;
        reset = 1'b1;
        #12;
        chk("rst_valid", 32'(bus.outValid), 0);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_ovf", 32'(bus.overflow), 0);
        chk("rst_err", 32'(bus.errCount), 0);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            bus.rxDone     = tbl[i].done;
            bus.rxErr      = tbl[i].err;
            bus.rxOut      = tbl[i].din;
            bus.outReady   = tbl[i].rdy;
            bus.clearFlags = tbl[i].clr;
            step();
            chk($sformatf("v%0d_valid", i), 32'(bus.outValid),
                32'(tbl[i].e_valid));
            if (tbl[i].e_valid)
                chk($sformatf("v%0d_byte", i), 32'(bus.outByte),
                    32'(tbl[i].e_byte));
            chk($sformatf("v%0d_count", i), 32'(bus.count),
                32'(tbl[i].e_count));
            chk($sformatf("v%0d_full", i), 32'(bus.full),
                32'(tbl[i].e_full));
            chk($sformatf("v%0d_ovf", i), 32'(bus.overflow),
                32'(tbl[i].e_ovf));
            chk($sformatf("v%0d_err", i), 32'(bus.errCount),
                32'(tbl[i].e_err));
        end
        bus.outReady = 0; bus.clearFlags = 0; bus.rxDone = 0;
        step();

        for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b0);
        chk("fill_full", 32'(bus.full), 1);
        chk("fill_count", 32'(bus.count), 16);
        chk("fill_ovf", 32'(bus.overflow), 0);
        push_byte(8'hAA, 1'b0);
        chk("ovf_set", 32'(bus.overflow), 1);
        chk("ovf_count", 32'(bus.count), 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d_valid", i), 32'(bus.outValid), 1);
            chk($sformatf("drain%0d_byte", i), 32'(bus.outByte), 32'(i));
            pop_one();
        end
        chk("drain_count", 32'(bus.count), 0);
        chk("drain_valid", 32'(bus.outValid), 0);
        chk("drain_ovf_sticky", 32'(bus.overflow), 1);
        bus.clearFlags = 1'b1;
        step();
        bus.clearFlags = 1'b0;
        chk("ovf_clear", 32'(bus.overflow), 0);

        for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i), 1'b0);
        bus.outReady = 1'b1;
        bus.rxOut    = 8'h77;
        bus.rxErr    = 1'b0;
        bus.rxDone   = 1'b1;
        step();
        bus.outReady = 1'b0;
        bus.rxDone   = 1'b0;
        chk("pp_count", 32'(bus.count), 16);
        chk("pp_ovf", 32'(bus.overflow), 0);
        chk("pp_full", 32'(bus.full), 1);
        step();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("pp%0d_byte", i), 32'(bus.outByte),
                (i == 15) ? 32'h77 : 32'(8'h11 + i));
            pop_one();
        end
        chk("pp_empty", 32'(bus.outValid), 0);

        bus.rxOut  = 8'h33;
        bus.rxDone = 1'b1;
        for (int i = 0; i < 50; i++) step();
        chk("held_count", 32'(bus.count), 1);
        bus.rxDone = 1'b0;
        step();
        for (int i = 0; i < 4; i++) push_byte(8'(8'h34 + i), 1'b0);
        chk("pre_rst_count", 32'(bus.count), 5);
        bus.rxOut  = 8'h99;
        bus.rxDone = 1'b1;
        reset      = 1'b1;
        #1;
        chk("async_rst_count", 32'(bus.count), 0);
        chk("async_rst_valid", 32'(bus.outValid), 0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("post_rst_nopush", 32'(bus.count), 0);
        chk("post_rst_valid", 32'(bus.outValid), 0);
        bus.rxDone = 1'b0;
        step();

        exp_wr = 8'h40;
        exp_rd = 8'h40;
        push_byte(exp_wr, 1'b0); exp_wr++;
        push_byte(exp_wr, 1'b0); exp_wr++;
        for (int i = 0; i < 40; i++) begin
            push_byte(exp_wr, 1'b0); exp_wr++;
            chk($sformatf("wrap%0d_byte", i), 32'(bus.outByte), 32'(exp_rd));
            pop_one();
            exp_rd++;
        end
        chk("wrap_count", 32'(bus.count), 2);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("wrap_tail%0d", i), 32'(bus.outByte), 32'(exp_rd));
            pop_one();
            exp_rd++;
        end
        chk("wrap_empty", 32'(bus.outValid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the `Uart8` receiver. It captures each completed byte from the receiver's `rxDone`/`rxErr`/`rxOut` outputs and stores good bytes in a first-word-fall-through FIFO. The stored bytes are presented to the consumer through a valid/ready port. Framing-error bytes are discarded and counted, and bytes that arrive while the FIFO is full set a sticky overflow flag.

## Interface

- `DEPTH`, default 16: number of byte entries; must be a power of two, ≥ 2.
- `AW`, default `$clog2(DEPTH)`: pointer width. Derived; do not override.

Ports, clock and reset first:
- `clk` in 1: system clock, the same clock as `Uart8`.
- `reset` in 1: asynchronous, active-high reset.
- `rxDone` in 1: from `Uart8`; a rising edge marks a completed frame.
- `rxErr` in 1: from `Uart8`; sampled in the same cycle as the `rxDone` rising edge.
- `rxOut` in 8: received byte from `Uart8`; sampled in the same cycle as the `rxDone` rising edge.
- `outValid` out 1: the FIFO holds at least one byte.
- `outByte` out 8: oldest stored byte; meaningful only while `outValid` = 1.
- `outReady` in 1: consumer accepts `outByte` this cycle.
- `count` out AW+1: number of stored bytes, 0..DEPTH.
- `full` out 1: `count` == DEPTH.
- `overflow` out 1: sticky; a good byte was dropped because the FIFO was full.
- `errCount` out 8: saturating count of discarded framing-error bytes.
- `clearFlags` in 1: synchronous clear of `overflow` and `errCount`.

## Operation

- **Edge detect.** A register `rxDonePrev` holds last cycle's `rxDone`. A write event (`push`) is `rxDone & ~rxDonePrev`. `rxDonePrev` resets to 1, so an `rxDone` that is already high when reset releases does not produce a push.
- **On a push with `rxErr` = 1:**
  - the byte is discarded;
  - `errCount` increments and saturates at 255;
  - the FIFO is untouched.
- **On a push with `rxErr` = 0:**
  - If not full, or if a pop happens in the same cycle: write `rxOut` at `wrPtr`, then `wrPtr` ← `wrPtr` + 1 modulo DEPTH.
  - If full and no pop this cycle: drop the byte, set `overflow` ← 1, leave the FIFO unchanged.
- **Pop** is `outValid & outReady`. On a pop, `rdPtr` ← `rdPtr` + 1 modulo DEPTH. `outReady` while empty is ignored.
- **Count update:**
  - push only: `count` + 1;
  - pop only: `count` − 1;
  - push and pop together: unchanged, including at `count` = DEPTH and at `count` = 1.
- **Derived outputs.** `outValid` = (`count` ≠ 0) and `full` = (`count` == DEPTH). Both are derived from the registered `count`, so each changes one cycle after the triggering event.
- **`outByte`** is the storage entry at `rdPtr`. The storage may be a register array or a memory with asynchronous read.
- **`clearFlags`:**
  - clears `overflow` to 0 and `errCount` to 0 on the next clock edge;
  - takes priority over a same-cycle set or increment;
  - does not affect FIFO contents.
- **Pointer wrap.** Pointers wrap naturally at AW bits. Fullness is tracked through `count`, not by comparing pointers.

## Timing

- **Reset values:**
  - `outValid` = 0, `count` = 0, `full` = 0;
  - `overflow` = 0, `errCount` = 0;
  - `rdPtr` = `wrPtr` = 0, `rxDonePrev` = 1;
  - `outByte` is don't-care.
  - Storage contents are not reset.
- **Reset mid-operation.** Asserting `reset` at any time immediately empties the FIFO: outputs go to their reset values asynchronously. A byte pushed in the cycle reset asserts is lost.
- **Latency.** Let the `rxDone` rising edge be sampled at clock edge N. Then `outValid` = 1 and `outByte` = that byte after edge N, i.e. visible during cycle N+1, provided the FIFO was empty.
- **No bypass.** An empty FIFO never presents a byte in the same cycle it is pushed.
- **Throughput.** One pop per cycle. A push needs `rxDone` to return low for at least one cycle before the next push can occur.
- **Held `rxDone`.** `rxDone` may stay high for many cycles; exactly one push occurs per rising edge.

## Test plan

- **Single byte.** After reset, drive `rxOut` = 8'h56, `rxErr` = 0, pulse `rxDone`.
  - Required: `outValid` rises one cycle later, `outByte` = 8'h56, `count` = 1.
  - Then assert `outReady` for one cycle. Required: `outValid` = 0 and `count` = 0 the next cycle.
- **Fill and overflow.** With `outReady` = 0, push bytes 8'h00..8'h0F (DEPTH = 16).
  - Required: `full` = 1, `overflow` = 0.
  - Push 8'hAA. Required: `overflow` = 1, `count` stays 16.
  - Drain. Required: bytes read out are 8'h00..8'h0F in order.
- **Framing error.** Push 8'h56 with `rxErr` = 1, three times.
  - Required: `errCount` = 3, `outValid` stays 0.
  - Pulse `clearFlags`. Required: `errCount` = 0.
- **Simultaneous push/pop at full.** At `count` = 16 with `outReady` = 1, push 8'h77 in the same cycle.
  - Required: `count` stays 16, `overflow` = 0, and 8'h77 is the last byte drained.
- **Held `rxDone` and reset.**
  - Hold `rxDone` high for 50 cycles. Required: `count` increments by exactly 1.
  - Assert `reset` while `count` = 5 and `rxDone` is high. Required: `count` = 0 and `outValid` = 0 immediately.
  - After reset releases with `rxDone` still high, require no push.
- **Pointer wrap.** Interleave 40 pushes and pops of an incrementing pattern with `count` kept between 1 and 3.
  - Required: every popped byte matches the expected sequence across the pointer wrap.
